// File: rtl/trig_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trig_pkg
// Description : Shared state, mode and slope encodings for the trigger
//               generator and its threshold comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_READY     = 3'd2,
        ST_FIRE      = 3'd3,
        ST_HOLDOFF   = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_NORMAL = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    localparam logic SLOPE_RISING  = 1'b0;
    localparam logic SLOPE_FALLING = 1'b1;

endpackage
`default_nettype wire

// File: rtl/trigger_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : trigger_generator_if
// Description : Sample stream, configuration and trigger handshake bundle.
//               master = sample/control source, slave = trigger generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface trigger_generator_if #(
    parameter int SAMPLE_WIDTH  = 12,
    parameter int HOLDOFF_WIDTH = 16
);
    logic                     i_sample_valid;
    logic [SAMPLE_WIDTH-1:0]  i_sample_data;
    logic [SAMPLE_WIDTH-1:0]  i_level;
    logic [SAMPLE_WIDTH-1:0]  i_hyst;
    logic                     i_slope;
    logic [1:0]               i_mode;
    logic                     i_arm;
    logic [HOLDOFF_WIDTH-1:0] i_holdoff;
    logic                     i_capture_done;
    logic                     o_trigger;
    logic                     o_armed;
    logic                     o_auto_fired;

    modport master (
        output i_sample_valid, i_sample_data, i_level, i_hyst, i_slope,
               i_mode, i_arm, i_holdoff, i_capture_done,
        input  o_trigger, o_armed, o_auto_fired
    );

    modport slave (
        input  i_sample_valid, i_sample_data, i_level, i_hyst, i_slope,
               i_mode, i_arm, i_holdoff, i_capture_done,
        output o_trigger, o_armed, o_auto_fired
    );
endinterface
`default_nettype wire

// File: rtl/trig_threshold.sv
`default_nettype none
// ============================================================================
// Module      : trig_threshold
// Description : Combinational saturating hysteresis thresholds and sample
//               compares. arm_hit = excursion beyond the hysteresis band,
//               fire_hit = sample at/past the trigger level.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_threshold
    import trig_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 12
) (
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [SAMPLE_WIDTH-1:0] level,
    input  logic [SAMPLE_WIDTH-1:0] hyst,
    input  logic                    slope,
    output logic                    arm_hit,
    output logic                    fire_hit
);
    localparam logic [SAMPLE_WIDTH-1:0] MAX_VAL = '1;

    logic [SAMPLE_WIDTH:0]   lo_diff;
    logic [SAMPLE_WIDTH:0]   hi_sum;
    logic [SAMPLE_WIDTH-1:0] lo_thr;
    logic [SAMPLE_WIDTH-1:0] hi_thr;

    // Band edges in one extra bit, clipped to the sample range. When a band
    // edge sits on a rail, a sample on that rail still counts as an excursion
    // provided it is strictly beyond the level (a sample at level never arms).
    always_comb begin
        lo_diff  = {1'b0, level} - {1'b0, hyst};
        hi_sum   = {1'b0, level} + {1'b0, hyst};
        lo_thr   = lo_diff[SAMPLE_WIDTH] ? '0 : lo_diff[SAMPLE_WIDTH-1:0];
        hi_thr   = hi_sum[SAMPLE_WIDTH] ? MAX_VAL : hi_sum[SAMPLE_WIDTH-1:0];
        arm_hit  = 1'b0;
        fire_hit = 1'b0;
        if (slope == SLOPE_RISING) begin
            arm_hit  = (sample < lo_thr) ||
                       ((lo_thr == '0) && (sample == '0) && (sample < level));
            fire_hit = (sample >= level);
        end else begin
            arm_hit  = (sample > hi_thr) ||
                       ((hi_thr == MAX_VAL) && (sample == MAX_VAL) && (sample > level));
            fire_hit = (sample <= level);
        end
    end
endmodule
`default_nettype wire

// File: rtl/trigger_generator.sv
`default_nettype none
// ============================================================================
// Module      : trigger_generator
// Description : Oscilloscope-style edge trigger with hysteresis, auto /
//               normal / single modes, auto timeout and post-trigger holdoff.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_generator
    import trig_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = 12,
    parameter int HOLDOFF_WIDTH = 16,
    parameter int AUTO_TIMEOUT  = 4096
) (
    input  logic               i_clk,
    input  logic               i_RESET,
    trigger_generator_if.slave bus
);
    localparam int                AUTO_W    = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);

    state_t                   state;
    state_t                   state_next;
    logic [SAMPLE_WIDTH-1:0]  level_lat;
    logic [SAMPLE_WIDTH-1:0]  hyst_lat;
    logic                     slope_lat;
    logic [1:0]               mode_lat;
    logic [AUTO_W-1:0]        auto_cnt;
    logic [HOLDOFF_WIDTH-1:0] hold_cnt;
    logic                     auto_fired;

    logic arm_hit;
    logic fire_hit;
    logic mode_auto;
    logic mode_single;
    logic auto_expire;
    logic hold_done;
    logic enter_armed;
    logic genuine_fire;
    logic forced_fire;

    trig_threshold #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_threshold (
        .sample   (bus.i_sample_data),
        .level    (level_lat),
        .hyst     (hyst_lat),
        .slope    (slope_lat),
        .arm_hit  (arm_hit),
        .fire_hit (fire_hit)
    );

    // Mode decode, auto timeout and holdoff completion qualifiers.
    always_comb begin
        mode_auto   = (mode_lat == MODE_AUTO);
        mode_single = (mode_lat == MODE_SINGLE);
        auto_expire = mode_auto && bus.i_sample_valid && (auto_cnt == AUTO_LAST);
        hold_done   = (hold_cnt >= bus.i_holdoff) ||
                      (bus.i_sample_valid &&
                       ((hold_cnt + HOLDOFF_WIDTH'(1)) >= bus.i_holdoff));
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_RESET) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state logic; a genuine crossing beats a simultaneous auto timeout.
    always_comb begin
        state_next   = state;
        enter_armed  = 1'b0;
        genuine_fire = 1'b0;
        forced_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_arm) begin
                    state_next  = ST_ARMED;
                    enter_armed = 1'b1;
                end
            end
            ST_ARMED: begin
                if (auto_expire) begin
                    state_next  = ST_FIRE;
                    forced_fire = 1'b1;
                end else if (bus.i_sample_valid && arm_hit) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                if (bus.i_sample_valid && fire_hit) begin
                    state_next   = ST_FIRE;
                    genuine_fire = 1'b1;
                end else if (auto_expire) begin
                    state_next  = ST_FIRE;
                    forced_fire = 1'b1;
                end
            end
            ST_FIRE: begin
                state_next = (bus.i_holdoff == '0) ? ST_WAIT_DONE : ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (hold_done) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.i_capture_done) begin
                    if (mode_single) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next  = ST_ARMED;
                        enter_armed = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Configuration latch, auto/holdoff counters and auto-fired flag.
    always_ff @(posedge i_clk) begin
        if (i_RESET) begin
            level_lat  <= '0;
            hyst_lat   <= '0;
            slope_lat  <= SLOPE_RISING;
            mode_lat   <= MODE_AUTO;
            auto_cnt   <= '0;
            hold_cnt   <= '0;
            auto_fired <= 1'b0;
        end else begin
            if (enter_armed) begin
                level_lat <= bus.i_level;
                hyst_lat  <= bus.i_hyst;
                slope_lat <= bus.i_slope;
                mode_lat  <= bus.i_mode;
                auto_cnt  <= '0;
            end else if (((state == ST_ARMED) || (state == ST_READY)) &&
                         mode_auto && bus.i_sample_valid) begin
                auto_cnt <= auto_cnt + AUTO_W'(1);
            end

            if (state == ST_FIRE)
                hold_cnt <= '0;
            else if ((state == ST_HOLDOFF) && bus.i_sample_valid)
                hold_cnt <= hold_cnt + HOLDOFF_WIDTH'(1);

            if (forced_fire)       auto_fired <= 1'b1;
            else if (genuine_fire) auto_fired <= 1'b0;
        end
    end

    assign bus.o_trigger    = (state == ST_FIRE);
    assign bus.o_armed      = (state == ST_ARMED) || (state == ST_READY);
    assign bus.o_auto_fired = auto_fired;
endmodule
`default_nettype wire

// File: doc/trigger_generator.md
TRIGGER_GENERATOR -- requirements
Module: trigger_generator

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 12, sets the ADC sample width.
REQ-002 Parameter HOLDOFF_WIDTH, default 16, sets the holdoff counter width.
REQ-003 Parameter AUTO_TIMEOUT, default 4096, is the valid-sample count before an auto-mode forced trigger.
REQ-004 i_clk  in  1  system clock, 25 MHz.
REQ-005 i_RESET  in  1  reset; synchronous, active-high; clock i_clk.
REQ-006 i_sample_valid  in  1  ADC sample strobe.
REQ-007 i_sample_data  in  SAMPLE_WIDTH  unsigned ADC sample.
REQ-008 i_level  in  SAMPLE_WIDTH  trigger level.
REQ-009 i_hyst  in  SAMPLE_WIDTH  hysteresis band.
REQ-010 i_slope  in  1  0 = rising edge, 1 = falling edge.
REQ-011 i_mode  in  2  00 = auto, 01 = normal, 10 = single; 11 is treated as normal.
REQ-012 i_arm  in  1  arm request pulse.
REQ-013 i_holdoff  in  HOLDOFF_WIDTH  valid samples ignored after a trigger.
REQ-014 i_capture_done  in  1  capture-complete flag from the frame buffer.
REQ-015 o_trigger  out  1  one-cycle trigger pulse to the frame buffer.
REQ-016 o_armed  out  1  high in the ARMED and READY states.
REQ-017 o_auto_fired  out  1  high while the last trigger was forced by the auto timeout.

Function
REQ-018 The FSM SHALL have the states IDLE, ARMED, READY, FIRE, HOLDOFF and WAIT_DONE.
REQ-019 The FSM SHALL move from IDLE to ARMED on i_arm=1 and SHALL ignore i_arm in all other states.
REQ-020 On each entry to ARMED, the block SHALL latch i_level, i_hyst, i_slope and i_mode, and SHALL clear the auto counter.
REQ-021 For rising slope, ARMED SHALL move to READY on a valid sample below sat0(level-hyst); READY SHALL move to FIRE on a valid sample >= level.
REQ-022 For falling slope, ARMED SHALL move to READY on a valid sample above satmax(level+hyst); READY SHALL move to FIRE on a valid sample <= level.
REQ-023 The threshold arithmetic SHALL use SAMPLE_WIDTH+1 bits and saturate to [0, 2^SAMPLE_WIDTH-1].
REQ-024 In auto mode, the auto counter SHALL increment on each valid sample in ARMED or READY; at AUTO_TIMEOUT the FSM SHALL move to FIRE and set o_auto_fired.
REQ-025 A genuine crossing in the same cycle as the auto timeout SHALL win, leaving o_auto_fired=0.
REQ-026 FIRE SHALL last exactly one cycle, during which o_trigger=1, so o_trigger rises one cycle after the qualifying sample.
REQ-027 HOLDOFF SHALL count i_holdoff valid samples, then move to WAIT_DONE; i_holdoff=0 SHALL pass straight to WAIT_DONE.
REQ-028 From WAIT_DONE on i_capture_done=1, single mode SHALL go to IDLE and auto/normal SHALL go to ARMED.
REQ-029 o_auto_fired SHALL clear on the next genuine trigger.
REQ-030 A sample held exactly at level with no prior excursion past the hysteresis band SHALL NOT trigger.

Reset
REQ-031 On i_RESET=1 at any point, including mid-capture, the FSM SHALL go to IDLE, all counters SHALL be 0, and o_trigger, o_armed and o_auto_fired SHALL be 0 on the next cycle.
REQ-032 i_RESET SHALL take priority over i_arm and sample events in the same cycle.

Structure
REQ-033 The state encodings, the mode codes (MODE_AUTO, MODE_NORMAL, MODE_SINGLE) and the slope codes SHALL reside in the shared package trig_pkg.
REQ-034 The saturating threshold and compare logic SHALL be the sub-module trig_threshold, which is combinational and instantiated once.
REQ-035 The RTL SHALL be single clock domain with no latches.

Verification
REQ-036 Normal mode, level=2048, hyst=64, rising; after arm, samples 1000, 1900, 2047, 2048 -> o_trigger pulses one cycle after the 2048 sample.
REQ-037 Normal mode, level=2048, hyst=64; samples oscillate 2000/2100 without going below 1984 -> no trigger.
REQ-038 Auto mode, AUTO_TIMEOUT=16, constant sample 100 -> o_trigger after the 16th valid sample, and o_auto_fired=1.
REQ-039 Single mode, falling, level=0, hyst=4095; sample 4095 then 0 -> one trigger, then IDLE after i_capture_done; a further crossing gives no trigger until a re-arm.
REQ-040 holdoff=8 in normal mode; a crossing 3 samples after a trigger is ignored; after capture_done and a re-arm, the next crossing triggers.
REQ-041 i_RESET asserted in READY -> o_armed=0 and the FSM is in IDLE the next cycle; a crossing sample in that same cycle produces no trigger.
